uart_rx_stream: RTL and testbench

UART_RX_STREAM -- requirements
Module: uart_rx_stream

---
 rtl/uart_rx_stream.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_stream.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_stream.sv
// UART receiver (8 data bits, LSB first, one stop bit) with a valid/ready byte output register.
// Define UART_RX_PARITY_EN to expect one even-parity bit after bit 7.
module uart_rx_stream #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  input  logic       rx_ready,
  output logic       overrun
);

  localparam int unsigned DIV  = CLK_FREQ / BAUD;
  localparam int unsigned HALF = DIV / 2;
  // Counter holds 0..DIV-1, so it never wraps inside a bit period.
  localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] DivLast  = CntW'(DIV - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic            prev_q, prev_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            frame_err_q, frame_err_d;
  logic            done_q, done_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_error_q, rx_error_d;
  logic            overrun_q, overrun_d;
  logic            rx_s;
  logic            fall;
  logic            par_err;

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;

  always_comb begin
    sync_d = {sync_q[0], uart_rx};
    prev_d = rx_s;
  end

  // Receive FSM: counts baud ticks and samples the synchronized line mid-bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = frame_err_q;
    done_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (fall) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == DivLast) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == DivLast) begin
          cnt_d     = '0;
          par_err_d = (^shift_q) ^ rx_s;
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (cnt_q == DivLast) begin
          cnt_d       = '0;
          frame_err_d = ~rx_s;
          done_d      = 1'b1;
          // Back to idle mid-stop-bit so the next start edge is caught on time.
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register: completion loads only if the slot is empty or being drained.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_error_d = rx_error_q;
    overrun_d  = 1'b0;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_error_d = frame_err_q | par_err;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sync_q      <= 2'b11;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_error_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_error_q  <= rx_error_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_error = rx_error_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench for uart_rx_stream: serial frames are built bit by bit and the
// accepted bytes are compared against an expected-byte queue.
module tb_uart_rx_stream;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int FRAME_BITS = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int FRAME_BITS = 10;
`endif
  // Start edge to rx_valid: start, data, parity bits plus half of the stop bit.
  localparam int LAT_EXP = (DIV * (2 * FRAME_BITS - 1)) / 2 + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       rx_ready;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [8:0] got_q[$];
  int         got_cyc_q[$];
  logic [8:0] exp_q[$];
  int         cyc = 0;
  int         ovr_cnt = 0;
  int         valid_cycles = 0;

  uart_rx_stream #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rx (uart_rx),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_error(rx_error),
    .rx_ready(rx_ready),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so negedge values are what the next posedge sees.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n === 1'b1) begin
      if (rx_valid && rx_ready) begin
        got_q.push_back({rx_error, rx_data});
        got_cyc_q.push_back(cyc);
      end
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (rx_valid) valid_cycles <= valid_cycles + 1;
    end
  end

  function automatic logic model_err(input logic stop_ok, input logic par_flip);
    return !stop_ok || (PAR_EN && par_flip);
  endfunction

  task automatic line_bit(input logic b);
    uart_rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_flip);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
    if (PAR_EN) line_bit((^d) ^ par_flip);
    line_bit(stop_ok);
    // A low stop bit leaves the line low; restore idle so the next start edge exists.
    if (!stop_ok) line_bit(1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_got(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic check_next(input string name, input int idx, input logic [8:0] exp);
    checks++;
    if (got_q.size() <= idx) begin
      errors++;
      $display("FAIL %s: byte %0d never accepted, expected err/data %h", name, idx, exp);
    end else if (got_q[idx] !== exp) begin
      errors++;
      $display("FAIL %s: got err/data %h expected %h", name, got_q[idx], exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; uart_rx = 1'b1; rx_ready = 1'b1;
    #2 rst_n = 1'b0;
    idle(3);
    checks++;
    if ({rx_data, rx_valid, rx_error, overrun} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000", {rx_data, rx_valid, rx_error, overrun});
    end
    @(negedge clk) rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_basic;
    int base = got_q.size();
    int vc0  = valid_cycles;
    int t0   = cyc;
    int lat;
    send_frame(8'h55, 1'b1, 1'b0);
    wait_got(base + 1, 4 * DIV);
    idle(2 * DIV);
    check_next("basic_0x55", base, 9'h055);
    checks++;
    if (valid_cycles - vc0 !== 1) begin
      errors++;
      $display("FAIL basic_valid_width: got %0d cycles expected 1", valid_cycles - vc0);
    end
    lat = (got_cyc_q.size() > base) ? got_cyc_q[base] - t0 : -1;
    checks++;
    if (lat < LAT_EXP - 4 || lat > LAT_EXP + 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles expected %0d +/-4", lat, LAT_EXP);
    end
  endtask

  task automatic test_framing;
    int base = got_q.size();
    send_frame(8'hA3, 1'b0, 1'b0);
    wait_got(base + 1, 4 * DIV);
    check_next("framing_0xA3", base, 9'h1A3);
  endtask

  task automatic test_glitch;
    int base = got_q.size();
    int vc0  = valid_cycles;
    int g    = $urandom_range(1, DIV / 2 - 3);
    uart_rx = 1'b0;
    idle(g);
    uart_rx = 1'b1;
    idle(3 * DIV);
    checks++;
    if (valid_cycles !== vc0) begin
      errors++;
      $display("FAIL glitch_no_valid: got %0d valid cycles expected 0", valid_cycles - vc0);
    end
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_got(base + 1, 4 * DIV);
    check_next("glitch_then_0x3C", base, 9'h03C);
  endtask

  task automatic test_overrun;
    int base = got_q.size();
    int o0   = ovr_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(DIV);
    checks++;
    if ({rx_valid, rx_error, rx_data} !== 10'h211) begin
      errors++;
      $display("FAIL overrun_hold: got valid/err/data %h expected 211",
               {rx_valid, rx_error, rx_data});
    end
    checks++;
    if (ovr_cnt - o0 !== 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d cycles expected 1", ovr_cnt - o0);
    end
    rx_ready = 1'b1;
    idle(2);
    check_next("overrun_accept_0x11", base, 9'h011);
    checks++;
    if (rx_valid !== 1'b0 || got_q.size() !== base + 1) begin
      errors++;
      $display("FAIL overrun_drain: got valid %b count %0d expected 0 and %0d",
               rx_valid, got_q.size() - base, 1);
    end
  endtask

  task automatic test_back_to_back;
    int base = got_q.size();
    int o0   = ovr_cnt;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 1'b0);
    wait_got(base + 16, 4 * DIV);
    for (int i = 0; i < 16; i++) check_next("back_to_back", base + i, 9'(i));
    checks++;
    if (ovr_cnt !== o0) begin
      errors++;
      $display("FAIL back_to_back_overrun: got %0d expected 0", ovr_cnt - o0);
    end
  endtask

  task automatic test_random;
    int base = got_q.size();
    logic [7:0] d;
    logic stop_ok, pf;
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      pf      = ($urandom_range(0, 3) == 0);
      exp_q.push_back({model_err(stop_ok, pf), d});
      send_frame(d, stop_ok, pf);
      idle($urandom_range(0, DIV));
    end
    wait_got(base + 20, 4 * DIV);
    for (int i = 0; i < 20; i++) check_next("random", base + i, exp_q[i]);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int base = got_q.size();
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_got(base + 2, 4 * DIV);
    check_next("parity_bad", base, 9'h107);
    check_next("parity_good", base + 1, 9'h007);
  endtask
`endif

  task automatic test_reset_midframe;
    int base;
    rx_ready = 1'b0;
    send_frame(8'h99, 1'b1, 1'b0);
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b0);
    rst_n = 1'b0;
    idle(2);
    checks++;
    if ({rx_data, rx_valid, rx_error, overrun} !== 11'h0) begin
      errors++;
      $display("FAIL reset_midframe_outputs: got %h expected 000",
               {rx_data, rx_valid, rx_error, overrun});
    end
    uart_rx = 1'b1;
    rx_ready = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(2 * DIV);
    base = got_q.size();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe_partial: got valid %b expected 0", rx_valid);
    end
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_got(base + 1, 4 * DIV);
    idle(DIV);
    check_next("reset_midframe_0x5A", base, 9'h05A);
    checks++;
    if (got_q.size() !== base + 1) begin
      errors++;
      $display("FAIL reset_midframe_count: got %0d bytes expected 1", got_q.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_framing();
    test_glitch();
    test_overrun();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
